// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - ID-stage data hazard detector with a shadow EX/MEM/WB pipeline
//
// Purpose:
//   Tracks the destination registers of the three instructions ahead of ID and
//   holds the ID instruction while one of its source operands is still being
//   produced. It also counts stall cycles and flags stalls that last longer
//   than the pipeline can legally need.
//
// Optional feature macro: FORWARDING_EN
//   undefined : no bypass network; EX or MEM producers stall (max 2 cycles)
//   defined   : full bypass; only a load in EX stalls (max 1 cycle)
//
// Ports:
//   clk                    rising-edge clock
//   reset_n                asynchronous active-low reset
//   id_valid               ID stage holds a real instruction
//   id_rs, id_rt           ID source register numbers
//   id_use_rs, id_use_rt   ID instruction actually reads rs / rt
//   id_rd                  ID destination register number
//   id_reg_write           ID instruction writes id_rd
//   id_mem_read            ID instruction is a load
//   id_flush               squash the ID instruction
//   stall                  hold PC and IF/ID this cycle
//   issue                  ID instruction enters EX at the next edge
//   bubble                 insert a NOP into ID/EX at the next edge
//   stall_count            saturating count of stall cycles
//   hazard_err             sticky: a stall outlived the legal maximum

module id_hazard_scoreboard (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [1:0]  id_rs,
  input  logic [1:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [1:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_flush,
  output logic        stall,
  output logic        issue,
  output logic        bubble,
  output logic [15:0] stall_count,
  output logic        hazard_err
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL1 = 2'd1,
    STALL2 = 2'd2
  } state_t;

  state_t state, state_next;

  // Shadow pipeline slots
  logic       ex_valid,  mem_valid,  wb_valid;
  logic [1:0] ex_rd,     mem_rd,     wb_rd;
  logic       ex_reg_write, mem_reg_write, wb_reg_write;
  logic       ex_mem_read,  mem_mem_read,  wb_mem_read;

  logic match_ex, match_mem, hazard_cond, hazard, active, err_set;

  assign match_ex  = ex_valid & ex_reg_write &
                     ((id_use_rs & (ex_rd == id_rs)) | (id_use_rt & (ex_rd == id_rt)));
  assign match_mem = mem_valid & mem_reg_write &
                     ((id_use_rs & (mem_rd == id_rs)) | (id_use_rt & (mem_rd == id_rt)));

  // WB never causes a hazard: the register file writes in the first half of
  // the cycle and reads in the second half.
`ifdef FORWARDING_EN
  assign hazard_cond = match_ex & ex_mem_read;
`else
  assign hazard_cond = match_ex | match_mem;
`endif

  // Flush wins over hazard: a squashed instruction never stalls.
  assign active = id_valid & ~id_flush;
  assign hazard = active & hazard_cond;
  assign stall  = hazard;
  assign issue  = active & ~hazard;
  assign bubble = ~issue;

  // The WB slot is architectural bookkeeping only.
  logic unused_slots;
  assign unused_slots = ^{wb_valid, wb_rd, wb_reg_write, wb_mem_read, mem_mem_read, match_mem};

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    if (!stall) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN:     state_next = STALL1;
        STALL1:  state_next = STALL2;
        STALL2:  state_next = STALL2;
        default: state_next = RUN;
      endcase
`ifdef FORWARDING_EN
      err_set = (state == STALL1) | (state == STALL2);
`else
      err_set = (state == STALL2);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RUN;
      ex_valid      <= 1'b0;
      ex_rd         <= 2'd0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_valid     <= 1'b0;
      mem_rd        <= 2'd0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= 2'd0;
      wb_reg_write  <= 1'b0;
      wb_mem_read   <= 1'b0;
      stall_count   <= 16'd0;
      hazard_err    <= 1'b0;
    end else begin
      state         <= state_next;
      wb_valid      <= mem_valid;
      wb_rd         <= mem_rd;
      wb_reg_write  <= mem_reg_write;
      wb_mem_read   <= mem_mem_read;
      mem_valid     <= ex_valid;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      mem_mem_read  <= ex_mem_read;
      ex_valid      <= issue;
      ex_rd         <= issue ? id_rd : 2'd0;
      ex_reg_write  <= issue & id_reg_write;
      ex_mem_read   <= issue & id_mem_read;
      if (stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (err_set) begin
        hazard_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - scoreboard bench for id_hazard_scoreboard

module tb_id_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [1:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt;
  logic        id_reg_write, id_mem_read, id_flush;
  logic        stall, issue, bubble;
  logic [15:0] stall_count;
  logic        hazard_err;

  always #5 clk = ~clk;

  id_hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_flush(id_flush), .stall(stall), .issue(issue), .bubble(bubble),
    .stall_count(stall_count), .hazard_err(hazard_err)
  );

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed { bit v; bit [1:0] rd; bit rw; bit mr; } ins_t;
  typedef struct { bit st; bit is; bit bu; bit er; bit [15:0] cnt; string tag; } exp_t;

  exp_t  expq[$];
  ins_t  hist[$];            // issued instructions, newest first: [0]=EX, [1]=MEM, [2]=WB
  int    consec = 0;         // consecutive stall cycles so far
  bit [15:0] m_cnt = 0;
  bit    m_err = 0;
  bit    pin_on = 0, do_pin = 0, do_unpin = 0, do_force_cnt = 0;
  int    errors = 0, checks = 0;

  task automatic chk(input string tag, input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s %s: got %0h want %0h", tag, name, act, want);
    end
  endtask

  task automatic step(input bit rst, input bit v, input bit [1:0] rs, input bit urs,
                      input bit [1:0] rt, input bit urt, input bit [1:0] rd,
                      input bit rw, input bit mr, input bit fl, input string tag);
    exp_t e;
    ins_t h;
    bit   cond, act;
    @(negedge clk);
    reset_n = rst; id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_flush = fl;
    if (do_unpin) begin
      release dut.ex_valid; release dut.ex_rd; release dut.ex_reg_write; release dut.ex_mem_read;
      pin_on = 0; do_unpin = 0;
    end
    if (do_pin) begin
      force dut.ex_valid = 1'b1; force dut.ex_rd = 2'd1;
      force dut.ex_reg_write = 1'b1; force dut.ex_mem_read = 1'b1;
      hist[0] = '{1'b1, 2'd1, 1'b1, 1'b1};
      pin_on = 1; do_pin = 0;
    end
    if (do_force_cnt) begin
      force dut.stall_count = 16'hFFFE;
      #1;
      release dut.stall_count;
      m_cnt = 16'hFFFE; do_force_cnt = 0;
    end
    if (!rst) begin
      hist = '{ins_t'(0), ins_t'(0), ins_t'(0)};
      consec = 0; m_cnt = 0; m_err = 0;
    end
    // A source is still being produced if a writer of it sits in the part of
    // the pipeline the bypass network cannot cover.
    cond = 0;
    for (int a = 0; a < (FWD ? 1 : 2); a++) begin
      h = hist[a];
      if (h.v && h.rw && ((urs && h.rd == rs) || (urt && h.rd == rt)) && (!FWD || h.mr))
        cond = 1;
    end
    act = v && !fl;
    e.st = act && cond; e.is = act && !cond; e.bu = !e.is;
    e.cnt = m_cnt; e.er = m_err; e.tag = tag;
    expq.push_back(e);
    if (rst) begin
      if (e.st) begin
        if (consec >= (FWD ? 1 : 2)) m_err = 1;
        consec++;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end else begin
        consec = 0;
      end
      hist.push_front(e.is ? ins_t'{1'b1, rd, rw, mr} : ins_t'(0));
      void'(hist.pop_back());
      if (pin_on) hist[0] = '{1'b1, 2'd1, 1'b1, 1'b1};
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "nop");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk(e.tag, "stall",       16'(stall),      16'(e.st));
        chk(e.tag, "issue",       16'(issue),      16'(e.is));
        chk(e.tag, "bubble",      16'(bubble),     16'(e.bu));
        chk(e.tag, "stall_count", stall_count,     e.cnt);
        chk(e.tag, "hazard_err",  16'(hazard_err), 16'(e.er));
      end
    end
  end

  initial begin : driver
    hist = '{ins_t'(0), ins_t'(0), ins_t'(0)};
    reset_n = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_use_rs = 0; id_use_rt = 0; id_reg_write = 0; id_mem_read = 0; id_flush = 0;

    step(0, 1, 1, 1, 2, 1, 3, 1, 0, 0, "reset");
    step(0, 1, 1, 1, 2, 1, 3, 1, 0, 1, "reset_flush");

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
           2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
           2'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, "rand");

    nop(3);
    step(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, "ld_r1");
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, "use_r1");

    nop(3);
    step(1, 1, 0, 0, 0, 0, 2, 1, 0, 0, "alu_r2");
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 2, 1, 3, 1, 0, 0, "use_r2");

    nop(3);
    step(1, 1, 0, 0, 0, 0, 3, 1, 1, 0, "ld_r3");
    step(1, 1, 3, 1, 3, 1, 0, 1, 0, 1, "flush_r3");
    nop(2);

    step(1, 1, 0, 0, 0, 0, 2, 1, 1, 0, "ld_r2");
    step(1, 1, 2, 0, 0, 1, 1, 1, 0, 0, "unused_rs");
    nop(3);

    step(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, "ld_r1b");
    step(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, "stall_pre_rst");
    step(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, "rst_mid_stall");
    step(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, "post_rst");
    nop(3);

    do_pin = 1; do_force_cnt = 1;
    step(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, "pinned");
    step(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, "pinned");
    step(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, "pinned");
    do_unpin = 1;
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, "unpinned");
    nop(3);
    step(1, 1, 0, 0, 0, 0, 2, 1, 0, 0, "sticky");

    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
